// File: rtl/sram_pkg.sv
// Shared types and helpers for the single-port SRAM requester controller.
package sram_pkg;

    // Controller states: IDLE accepts requests, RMW completes a byte-masked write.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RMW  = 1'b1
    } state_t;

    // Byte-lane merge for read-modify-write: new byte where enabled, old byte otherwise.
    function automatic logic [7:0] merge_byte(input logic       keep_new,
                                              input logic [7:0] new_byte,
                                              input logic [7:0] old_byte);
        return keep_new ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/sram_sp.sv
// Behavioural single-port synchronous-read SRAM: DO updates one edge after a read.
module sram_sp #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             EN,
    input  logic             WE,
    input  logic [AW-1:0]    ADDR,
    input  logic [WIDTH-1:0] DI,
    output logic [WIDTH-1:0] DO
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write on EN&WE; read registers the addressed word into DO on EN&!WE.
    always_ff @(posedge CLK) begin
        if (EN) begin
            if (WE) mem[ADDR] <= DI;
            else    DO        <= mem[ADDR];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; read data is the head entry (show-ahead).
module sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap modulo DEPTH, so non-power-of-two depths work too.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; only the pointers and count define which entries are live.
    // NOTE: memory arrays are not reset - clearing count/pointers already makes them invalid.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop keeps count.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_sp_ctrl.sv
// Requester-side controller: valid/ready requests to SRAM pins, with
// read-modify-write for byte-masked writes and a credited response FIFO.
module sram_sp_ctrl
    import sram_pkg::*;
#(
    parameter  int WIDTH     = 32,
    parameter  int DEPTH     = 1024,
    parameter  int RSP_DEPTH = 4,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               req_val,
    output logic               req_rdy,
    input  logic               req_we,
    input  logic [WIDTH/8-1:0] req_be,
    input  logic [AW-1:0]      req_addr,
    input  logic [WIDTH-1:0]   req_wdata,
    output logic               rsp_val,
    input  logic               rsp_rdy,
    output logic [WIDTH-1:0]   rsp_rdata,
    output logic               sram_en,
    output logic               sram_we,
    output logic [AW-1:0]      sram_addr,
    output logic [WIDTH-1:0]   sram_di,
    input  logic [WIDTH-1:0]   sram_do
);

    localparam int NB = WIDTH / 8;
    localparam int CW = $clog2(RSP_DEPTH + 1);

    state_t           state;
    state_t           next_state;
    logic             inflight;
    logic             rd_accept;
    logic             rmw_start;
    logic [AW-1:0]    lat_addr;
    logic [NB-1:0]    lat_be;
    logic [WIDTH-1:0] lat_wdata;
    logic [WIDTH-1:0] merged;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW:0]      occupancy;
    logic             credit_ok;

    // A read in flight has a reserved FIFO slot, so the FIFO can never overflow.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
    assign credit_ok = !fifo_full && (occupancy < (CW+1)'(RSP_DEPTH));

    assign rsp_val = RST_N && !fifo_empty;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .push      (inflight),
        .push_data (sram_do),
        .pop       (rsp_val && rsp_rdy),
        .pop_data  (rsp_rdata),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Merge latched write bytes over the old word returned by the RMW read.
    always_comb begin
        merged = '0;
        for (int i = 0; i < NB; i++) begin
            merged[i*8 +: 8] = merge_byte(lat_be[i], lat_wdata[i*8 +: 8], sram_do[i*8 +: 8]);
        end
    end

    // Next-state and SRAM pin decode; everything is forced idle while in reset.
    // NOTE: defaults first so every path assigns every output - no latches.
    always_comb begin
        next_state = state;
        req_rdy    = 1'b0;
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = req_addr;
        sram_di    = req_wdata;
        rd_accept  = 1'b0;
        rmw_start  = 1'b0;
        if (!RST_N) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    req_rdy = credit_ok;
                    if (req_val && credit_ok) begin
                        if (!req_we) begin
                            sram_en   = 1'b1;
                            rd_accept = 1'b1;
                        end else if (&req_be) begin
                            sram_en = 1'b1;
                            sram_we = 1'b1;
                        end else if (|req_be) begin
                            sram_en    = 1'b1;
                            rmw_start  = 1'b1;
                            next_state = ST_RMW;
                        end
                    end
                end
                ST_RMW: begin
                    sram_en    = 1'b1;
                    sram_we    = 1'b1;
                    sram_addr  = lat_addr;
                    sram_di    = merged;
                    next_state = ST_IDLE;
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // State register and read-inflight flag.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            inflight <= 1'b0;
        end else begin
            state    <= next_state;
            inflight <= rd_accept;
        end
    end

    // Capture the masked write while its old-data read is issued.
    always_ff @(posedge CLK) begin
        if (rmw_start) begin
            lat_addr  <= req_addr;
            lat_be    <= req_be;
            lat_wdata <= req_wdata;
        end
    end

endmodule

// File: tb/tb_sram_sp_ctrl.sv
// Directed bench for sram_sp_ctrl driving the behavioural sram_sp.
module tb_sram_sp_ctrl;

    localparam int WIDTH = 32;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic             CLK;
    logic             RST_N;
    logic             req_val;
    logic             req_rdy;
    logic             req_we;
    logic [3:0]       req_be;
    logic [AW-1:0]    req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_val;
    logic             rsp_rdy;
    logic [WIDTH-1:0] rsp_rdata;
    logic             sram_en;
    logic             sram_we;
    logic [AW-1:0]    sram_addr;
    logic [WIDTH-1:0] sram_di;
    logic [WIDTH-1:0] sram_do;

    int vectors     = 0;
    int miscompares = 0;
    int we_pulses   = 0;

    int          s_acc, s_first_acc, s_last_acc;
    int          s_nrsp, s_first_rsp, s_last_rsp;
    logic [31:0] s_data [16];

    sram_sp_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RSP_DEPTH(4)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .req_val   (req_val),
        .req_rdy   (req_rdy),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_val   (rsp_val),
        .rsp_rdy   (rsp_rdy),
        .rsp_rdata (rsp_rdata),
        .sram_en   (sram_en),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_di   (sram_di),
        .sram_do   (sram_do)
    );

    sram_sp #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_sram (
        .CLK  (CLK),
        .EN   (sram_en),
        .WE   (sram_we),
        .ADDR (sram_addr),
        .DI   (sram_di),
        .DO   (sram_do)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (sram_en === 1'b1 && sram_we === 1'b1) we_pulses++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] pat(input int a);
        return 32'hC0DE_0000 ^ (32'(a) * 32'h0001_0101);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input int addr, input logic [31:0] data, input logic [3:0] be,
                            input bit chk, input string tag);
        req_val   = 1'b1;
        req_we    = 1'b1;
        req_be    = be;
        req_addr  = AW'(addr);
        req_wdata = data;
        #1;
        if (chk) check({tag, "_rdy"}, 32'(req_rdy), 32'd1);
        cyc();
        req_val = 1'b0;
    endtask

    task automatic do_read(input int addr, input logic [31:0] exp, input string tag);
        req_val  = 1'b1;
        req_we   = 1'b0;
        req_addr = AW'(addr);
        #1;
        check({tag, "_rdy"}, 32'(req_rdy), 32'd1);
        check({tag, "_en_we"}, {30'd0, sram_en, sram_we}, 32'h2);
        cyc();
        req_val = 1'b0;
        #1;
        check({tag, "_val_e1"}, 32'(rsp_val), 32'd0);
        cyc();
        check({tag, "_val_e2"}, 32'(rsp_val), 32'd1);
        check({tag, "_data"}, rsp_rdata, exp);
        cyc();
    endtask

    task automatic stream(input int base, input int n, input int pre_acc, input int max_cyc);
        bit a_now;
        bit r_now;
        int c;
        s_acc = pre_acc; s_nrsp = 0; c = 0;
        s_first_acc = -1; s_last_acc = -1; s_first_rsp = -1; s_last_rsp = -1;
        req_we   = 1'b0;
        req_val  = (s_acc < n);
        req_addr = AW'(base + s_acc);
        #1;
        while (s_nrsp < n && c < max_cyc) begin
            a_now = req_val && req_rdy;
            r_now = rsp_val && rsp_rdy;
            if (a_now) begin
                if (s_first_acc < 0) s_first_acc = c;
                s_last_acc = c;
            end
            if (r_now) begin
                if (s_nrsp < 16) s_data[s_nrsp] = rsp_rdata;
                if (s_first_rsp < 0) s_first_rsp = c;
                s_last_rsp = c;
                s_nrsp++;
            end
            @(posedge CLK);
            #1;
            c++;
            if (a_now) s_acc++;
            req_val  = (s_acc < n);
            req_addr = AW'(base + s_acc);
            #1;
        end
        req_val = 1'b0;
        check("stream_rsp_count", 32'(s_nrsp), 32'(n));
    endtask

    initial begin
        int acc;
        bit a;
        int we_before;

        RST_N = 1'b0; req_val = 1'b1; req_we = 1'b0; req_be = 4'hF;
        req_addr = '0; req_wdata = '0; rsp_rdy = 1'b1;

        // Reset: outputs held idle even with a request offered.
        cyc(); cyc();
        check("rst_rdy", 32'(req_rdy), 32'd0);
        check("rst_rsp_val", 32'(rsp_val), 32'd0);
        check("rst_en_we", {30'd0, sram_en, sram_we}, 32'd0);
        req_val = 1'b0;
        RST_N   = 1'b1;
        cyc();
        check("post_rst_rdy", 32'(req_rdy), 32'd1);

        // Full write then read with 2-edge latency.
        req_val = 1'b1; req_we = 1'b1; req_be = 4'hF; req_addr = 10'd5; req_wdata = 32'hDEADBEEF;
        #1;
        check("fw_en_we", {30'd0, sram_en, sram_we}, 32'h3);
        check("fw_di", sram_di, 32'hDEADBEEF);
        cyc();
        req_val = 1'b0;
        do_read(5, 32'hDEADBEEF, "rd5");

        // Partial write: RMW cycle blocks acceptance and merges bytes.
        do_write(7, 32'h11223344, 4'hF, 1'b0, "pre7");
        req_val = 1'b1; req_we = 1'b1; req_be = 4'b0101; req_addr = 10'd7; req_wdata = 32'hAABBCCDD;
        #1;
        check("pw_rdy", 32'(req_rdy), 32'd1);
        check("pw_rd_issue", {30'd0, sram_en, sram_we}, 32'h2);
        cyc();
        req_we = 1'b0;
        #1;
        check("rmw_rdy", 32'(req_rdy), 32'd0);
        check("rmw_en_we", {30'd0, sram_en, sram_we}, 32'h3);
        check("rmw_addr", 32'(sram_addr), 32'd7);
        check("rmw_di", sram_di, 32'h11BB33DD);
        cyc();
        req_val = 1'b0;
        do_read(7, 32'h11BB33DD, "rd7");

        // be=0 write: accepted with no SRAM access, word unchanged.
        do_write(3, 32'h00000055, 4'hF, 1'b0, "pre3");
        req_val = 1'b1; req_we = 1'b1; req_be = 4'h0; req_addr = 10'd3; req_wdata = 32'hFFFFFFFF;
        #1;
        check("be0_rdy", 32'(req_rdy), 32'd1);
        check("be0_en", 32'(sram_en), 32'd0);
        cyc();
        req_val = 1'b0;
        do_read(3, 32'h00000055, "rd3");

        // Top address reads back without aliasing onto address 0.
        do_write(DEPTH - 1, 32'hCAFEF00D, 4'hF, 1'b1, "wtop");
        do_write(0, 32'h0BADF00D, 4'hF, 1'b1, "w0");
        do_read(DEPTH - 1, 32'hCAFEF00D, "rdtop");

        // Backpressure: with rsp_rdy=0 only 4 reads fit; then drain in order.
        for (int i = 16; i < 22; i++) do_write(i, pat(i), 4'hF, 1'b0, "pre_bp");
        rsp_rdy = 1'b0;
        acc = 0;
        req_val = 1'b1; req_we = 1'b0; req_addr = 10'd16;
        for (int k = 0; k < 10; k++) begin
            #1;
            a = req_rdy;
            cyc();
            if (a) begin
                acc++;
                req_addr = AW'(16 + acc);
            end
        end
        #1;
        check("bp_accepted", 32'(acc), 32'd4);
        check("bp_rdy_low", 32'(req_rdy), 32'd0);
        check("bp_rsp_val", 32'(rsp_val), 32'd1);
        check("bp_hold_data", rsp_rdata, pat(16));
        rsp_rdy = 1'b1;
        stream(16, 6, acc, 40);
        for (int i = 0; i < 6; i++) check("bp_order", s_data[i], pat(16 + i));

        // Streaming: 16 reads, one per cycle, responses without bubbles.
        cyc();
        for (int i = 32; i < 48; i++) do_write(i, pat(i), 4'hF, 1'b0, "pre_st");
        stream(32, 16, 0, 60);
        check("st_accepts", 32'(s_acc), 32'd16);
        check("st_acc_span", 32'(s_last_acc - s_first_acc), 32'd15);
        check("st_rsp_span", 32'(s_last_rsp - s_first_rsp), 32'd15);
        check("st_latency", 32'(s_first_rsp - s_first_acc), 32'd2);
        for (int i = 0; i < 16; i++) check("st_order", s_data[i], pat(32 + i));

        // Reset in the RMW cycle: no write, FIFO emptied, word unchanged.
        cyc();
        do_write(9, 32'h12345678, 4'hF, 1'b0, "pre9");
        rsp_rdy = 1'b0;
        req_val = 1'b1; req_we = 1'b0; req_addr = 10'd5;
        cyc();
        req_val = 1'b0;
        cyc();
        check("rr_fifo_loaded", 32'(dut.u_rsp_fifo.count), 32'd1);
        req_val = 1'b1; req_we = 1'b1; req_be = 4'b0011; req_addr = 10'd9; req_wdata = 32'hFFFFFFFF;
        #1;
        check("rr_pw_rdy", 32'(req_rdy), 32'd1);
        cyc();
        req_val = 1'b0;
        RST_N   = 1'b0;
        #1;
        check("rr_en_we", {30'd0, sram_en, sram_we}, 32'd0);
        check("rr_rsp_val", 32'(rsp_val), 32'd0);
        we_before = we_pulses;
        cyc();
        check("rr_no_we_pulse", 32'(we_pulses), 32'(we_before));
        check("rr_fifo_count", 32'(dut.u_rsp_fifo.count), 32'd0);
        RST_N   = 1'b1;
        rsp_rdy = 1'b1;
        cyc();
        check("rr_rsp_val_after", 32'(rsp_val), 32'd0);
        do_read(9, 32'h12345678, "rd9");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_sp_ctrl.md
Name: sram_sp_ctrl

Overview:
- Requester-side controller for the single-port synchronous-read SRAM model (sram_sp).
- Converts a valid/ready request stream (read, full write, byte-masked write) into the SRAM EN/WE/ADDR/DI pins.
- Captures DO one cycle after a read and returns it on a valid/ready response stream with backpressure.
- Byte-masked writes use read-modify-write, because the SRAM has no byte enables.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8.
- DEPTH, 1024, SRAM words; address width is AW = $clog2(DEPTH), derived and not overridable.
- RSP_DEPTH, 4, response FIFO entries; must be >= 3 to sustain one read per cycle.

Ports:
- CLK  in  1  single clock.
- RST_N  in  1  reset, synchronous, active-low.
- req_val  in  1  request valid.
- req_rdy  out  1  request ready; a request transfers when req_val && req_rdy.
- req_we  in  1  1 = write, 0 = read.
- req_be  in  WIDTH/8  byte enables; writes only.
- req_addr  in  AW  word address.
- req_wdata  in  WIDTH  write data.
- rsp_val  out  1  read data valid.
- rsp_rdy  in  1  consumer ready.
- rsp_rdata  out  WIDTH  read data.
- sram_en  out  1  to SRAM EN.
- sram_we  out  1  to SRAM WE.
- sram_addr  out  AW  to SRAM ADDR.
- sram_di  out  WIDTH  to SRAM DI.
- sram_do  in  WIDTH  from SRAM DO; valid the cycle after an EN=1, WE=0 access.

Behaviour:
- Reset (RST_N=0 at a CLK edge):
  - FSM goes to IDLE; FIFO count, pointers and inflight flag clear.
  - While RST_N=0: req_rdy=0, rsp_val=0, sram_en=0, sram_we=0.
- Mid-operation reset: a pending RMW is abandoned and no SRAM write is issued; FIFO contents are discarded.
- Outputs are combinational from state: sram_en/we/addr/di are driven in the same cycle a request is accepted, so the SRAM samples them at that edge.
- FSM states: IDLE, RMW.
- IDLE:
  - req_rdy = (count + inflight < RSP_DEPTH).
  - Read accepted: sram_en=1, sram_we=0; inflight<=1.
  - Write with req_be all ones: sram_en=1, sram_we=1, sram_di=req_wdata; no response; stay in IDLE.
  - Write with req_be all zero: accepted, sram_en=0, no response, no SRAM access.
  - Partial write: issue a read (en=1, we=0); latch addr, be and wdata; go to RMW.
- RMW (one cycle):
  - req_rdy=0.
  - sram_en=1, sram_we=1, sram_addr=latched addr.
  - sram_di byte i = be[i] ? wdata byte i : sram_do byte i.
  - Return to IDLE. Merge data never enters the FIFO.
- Read latency and throughput:
  - Read accepted at edge N: sram_do is valid in cycle N+1 and is pushed into the FIFO at edge N+1.
  - rsp_val rises in cycle N+1 after that edge, i.e. 2 edges from acceptance.
  - Back-to-back reads sustain one per cycle when RSP_DEPTH >= 3 and rsp_rdy=1.
- Ordering: strictly in order. A read following a write to the same address returns the new data; a partial write completes before the next acceptance.
- FIFO:
  - Push and pop in the same cycle leaves count unchanged.
  - Pointers wrap modulo RSP_DEPTH.
  - Never overflows, because the credit check counts inflight reads.
  - rsp_rdata is held stable while rsp_val=1 and rsp_rdy=0.
- Throughput limits:
  - A partial write occupies 2 cycles.
  - With rsp_rdy=0, at most RSP_DEPTH reads are accepted, then req_rdy=0 until pops occur.

Decomposition:
- Shared package sram_pkg:
  - localparams ST_IDLE and ST_RMW;
  - a function for the byte-merge.
- Sub-module sync_fifo: parameterised WIDTH/DEPTH, synchronous active-low reset, outputs count/full/empty.
- Top level holds the FSM, the credit logic and the RMW latches.
- The bench instantiates sram_sp alongside the controller.

Test Plan:
- Full write then read: write addr 5 = 0xDEADBEEF, then read addr 5 -> rsp_rdata=0xDEADBEEF, rsp_val rising 2 edges after the read is accepted.
- Partial write: addr 7 preset to 0x11223344; write be=4'b0101, wdata=0xAABBCCDD -> req_rdy=0 for 1 cycle; a following read returns 0x11BB33DD.
- Backpressure: rsp_rdy=0 and 6 read requests offered -> exactly 4 accepted and req_rdy held 0; release rsp_rdy -> 4 responses in address order, then the remaining 2.
- Streaming: 16 consecutive reads with rsp_rdy=1 -> 16 accepts in 16 cycles and 16 in-order responses with no bubbles.
- be=0 write to addr 3 holding 0x55 -> sram_en stays 0 and a read returns 0x55. Read addr DEPTH-1 -> correct data with no address wrap error.
- Reset during RMW: RST_N=0 in the RMW cycle -> no sram_we pulse, the word is unchanged, rsp_val=0, and FIFO count=0 after reset.
